// File: rtl/router_pkg.sv
// Shared types and constants for the router input-stage packet controller.
package router_pkg;

   typedef enum logic [2:0] {
      GET_SOURCE   = 3'd0,
      GET_DEST     = 3'd1,
      STORE_HEADER = 3'd2,
      GET_SIZE     = 3'd3,
      LOAD_DATA    = 3'd4,
      GET_CRC      = 3'd5,
      CRC_WAIT     = 3'd6,
      DROP         = 3'd7
   } state_t;

   localparam logic [7:0] TS1       = 8'h81;
   localparam logic [7:0] TS2       = 8'h82;
   localparam logic [7:0] TS3       = 8'h83;
   localparam int         MAX_DSIZE = 7;

   function automatic logic is_accepting(input state_t s);
      return (s inside {GET_SOURCE, GET_DEST, STORE_HEADER, GET_SIZE, LOAD_DATA, GET_CRC});
   endfunction

   function automatic logic is_writing(input state_t s);
      return (s inside {GET_DEST, STORE_HEADER, GET_SIZE, LOAD_DATA, GET_CRC});
   endfunction

endpackage

// File: rtl/router_pkt_ctrl.sv
// Packet-sequencing FSM for the 1x3 router input stage.
// Optional mid-packet idle timeout is enabled with `define ROUTER_TIMEOUT_EN.
//
// state        | meaning
// GET_SOURCE   | idle, waiting for the source byte
// GET_DEST     | source taken; trust check, waiting for dest byte
// STORE_HEADER | sender holds its byte while the header is stored
// GET_SIZE     | capture payload length
// LOAD_DATA    | stream payload bytes, cnt counts down
// GET_CRC      | capture CRC byte
// CRC_WAIT     | single cycle: report pkt_done / crc_err
// DROP         | untrusted packet, swallow bytes until valid drops
module router_pkt_ctrl
   import router_pkg::*;
`ifdef ROUTER_TIMEOUT_EN
   #(parameter int TIMEOUT_CYC = 16)
`endif
   (
   input  logic       clk1,
   input  logic       reset,
   input  logic       packet_valid_i,
   input  logic [2:0] pkt_size,
   input  logic       fifo_full,
   input  logic       trusted_source,
   input  logic       crc_checked,
   input  logic       err,
   output logic       get_source,
   output logic       get_dest,
   output logic       store_header,
   output logic       get_size,
   output logic       load_data,
   output logic       get_crc,
   output logic       full_state,
   output logic       write_enb,
   output logic       packet_send,
   output logic       pkt_done,
   output logic       crc_err,
   output logic       pkt_abort
);

   state_t     state;
   logic [2:0] cnt;
   logic       accepting;
   logic       accept;
   logic       dropping;
   logic       wr_next;
   logic       timeout_hit;
   logic       unused;

   // crc_checked is informational here: CRC_WAIT is always a single cycle.
   assign unused = crc_checked;

   assign accepting  = is_accepting(state);
   assign accept     = packet_valid_i && !fifo_full && accepting;
   assign full_state = fifo_full && accepting;
   assign dropping   = (state == GET_DEST) && !trusted_source && !fifo_full;
   assign wr_next    = accept && is_writing(state) && !dropping;

   assign packet_send = (accepting && (state != STORE_HEADER) && !fifo_full) || (state == DROP);

   assign get_source   = (state == GET_SOURCE);
   assign get_dest     = (state == GET_DEST);
   assign store_header = (state == STORE_HEADER);
   assign get_size     = (state == GET_SIZE);
   assign load_data    = (state == LOAD_DATA);
   assign get_crc      = (state == GET_CRC);

`ifdef ROUTER_TIMEOUT_EN
   logic [4:0] idle_cnt;
   logic       idle;

   assign idle        = !packet_valid_i && !(state inside {GET_SOURCE, CRC_WAIT, DROP});
   assign timeout_hit = idle && (idle_cnt == 5'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk1) begin
      if (!reset)
         idle_cnt <= '0;
      else if (accept || timeout_hit || (state inside {GET_SOURCE, CRC_WAIT, DROP}))
         idle_cnt <= '0;
      else if (idle)
         idle_cnt <= idle_cnt + 5'd1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk1) begin
      if (!reset) begin
         state     <= GET_SOURCE;
         cnt       <= '0;
         write_enb <= 1'b0;
         pkt_done  <= 1'b0;
         crc_err   <= 1'b0;
         pkt_abort <= 1'b0;
      end else begin
         write_enb <= wr_next;
         pkt_done  <= 1'b0;
         crc_err   <= 1'b0;
         pkt_abort <= 1'b0;
         if (timeout_hit) begin
            state     <= GET_SOURCE;
            pkt_abort <= 1'b1;
         end else begin
            case (state)
               GET_SOURCE:
                  if (accept) state <= GET_DEST;
               GET_DEST:
                  if (dropping) begin
                     state     <= DROP;
                     pkt_abort <= 1'b1;
                  end else if (accept) begin
                     state <= STORE_HEADER;
                  end
               STORE_HEADER:
                  if (accept) state <= GET_SIZE;
               GET_SIZE:
                  if (accept) begin
                     cnt   <= pkt_size;
                     state <= (pkt_size == 3'd0) ? GET_CRC : LOAD_DATA;
                  end
               LOAD_DATA:
                  if (accept) begin
                     if (cnt != 3'd0) cnt <= cnt - 3'd1;
                     if (cnt <= 3'd1) state <= GET_CRC;
                  end
               GET_CRC:
                  if (accept) state <= CRC_WAIT;
               CRC_WAIT: begin
                  pkt_done <= 1'b1;
                  crc_err  <= err;
                  state    <= GET_SOURCE;
               end
               DROP:
                  if (!packet_valid_i) state <= GET_SOURCE;
               default:
                  state <= GET_SOURCE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Directed self-checking bench for router_pkt_ctrl (default build; timeout case when ROUTER_TIMEOUT_EN is defined).
module tb_router_pkt_ctrl;

   logic       clk1 = 1'b0;
   logic       reset;
   logic       packet_valid_i;
   logic [2:0] pkt_size;
   logic       fifo_full;
   logic       trusted_source;
   logic       crc_checked;
   logic       err;
   logic       get_source, get_dest, store_header, get_size, load_data, get_crc;
   logic       full_state, write_enb, packet_send, pkt_done, crc_err, pkt_abort;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt, done_cnt, abort_cnt;
   logic crc_seen;

   always #5 clk1 = ~clk1;

   router_pkt_ctrl dut (
      .clk1(clk1), .reset(reset), .packet_valid_i(packet_valid_i), .pkt_size(pkt_size),
      .fifo_full(fifo_full), .trusted_source(trusted_source), .crc_checked(crc_checked), .err(err),
      .get_source(get_source), .get_dest(get_dest), .store_header(store_header),
      .get_size(get_size), .load_data(load_data), .get_crc(get_crc),
      .full_state(full_state), .write_enb(write_enb), .packet_send(packet_send),
      .pkt_done(pkt_done), .crc_err(crc_err), .pkt_abort(pkt_abort)
   );

   function automatic logic [5:0] strobes();
      return {get_source, get_dest, store_header, get_size, load_data, get_crc};
   endfunction

   task automatic tick();
      @(posedge clk1);
      #1;
      if (write_enb) wr_cnt++;
      if (pkt_done) begin
         done_cnt++;
         crc_seen = crc_err;
      end
      if (pkt_abort) abort_cnt++;
   endtask

   task automatic clear_counts();
      wr_cnt = 0; done_cnt = 0; abort_cnt = 0; crc_seen = 1'bx;
   endtask

   task automatic test_reset();
      reset = 1'b0; packet_valid_i = 1'b0; pkt_size = 3'd0; fifo_full = 1'b0;
      trusted_source = 1'b1; crc_checked = 1'b1; err = 1'b0;
      tick(); tick();
      n_cmp++; if (strobes() !== 6'b100000) begin n_err++; $display("FAIL reset_strobes got %b want 100000", strobes()); end
      n_cmp++; if ({write_enb, pkt_done, crc_err, pkt_abort} !== 4'b0000) begin n_err++; $display("FAIL reset_regs got %b want 0000", {write_enb, pkt_done, crc_err, pkt_abort}); end
      n_cmp++; if (packet_send !== 1'b1 || full_state !== 1'b0) begin n_err++; $display("FAIL reset_send got send=%b full=%b want 1/0", packet_send, full_state); end
      reset = 1'b1;
      tick();
   endtask

   // Trusted packet with N data bytes, valid held high for all N+5 accepted bytes.
   task automatic test_good_packet(input logic [2:0] size, input logic err_v, input int exp_wr, input string tag);
      clear_counts();
      trusted_source = 1'b1; err = err_v; pkt_size = size; packet_valid_i = 1'b1;
      for (int i = 0; i < int'(size) + 5; i++) begin
         tick();
         if (i == 1) begin
            n_cmp++; if (store_header !== 1'b1 || packet_send !== 1'b0) begin n_err++; $display("FAIL %s_hdr got hdr=%b send=%b want 1/0", tag, store_header, packet_send); end
         end
      end
      packet_valid_i = 1'b0;
      tick(); tick();
      n_cmp++; if (wr_cnt !== exp_wr) begin n_err++; $display("FAIL %s_writes got %0d want %0d", tag, wr_cnt, exp_wr); end
      n_cmp++; if (done_cnt !== 1 || crc_seen !== err_v) begin n_err++; $display("FAIL %s_done got done=%0d crc_err=%b want 1/%b", tag, done_cnt, crc_seen, err_v); end
      n_cmp++; if (get_source !== 1'b1) begin n_err++; $display("FAIL %s_idle got get_source=%b want 1", tag, get_source); end
      err = 1'b0;
   endtask

   task automatic test_drop();
      clear_counts();
      trusted_source = 1'b0; pkt_size = 3'd3; packet_valid_i = 1'b1;
      tick();
      n_cmp++; if (get_dest !== 1'b1 || pkt_abort !== 1'b0) begin n_err++; $display("FAIL drop_dest got dest=%b abort=%b want 1/0", get_dest, pkt_abort); end
      tick();
      n_cmp++; if (pkt_abort !== 1'b1 || strobes() !== 6'b000000 || packet_send !== 1'b1) begin n_err++; $display("FAIL drop_enter got abort=%b strb=%b send=%b want 1/000000/1", pkt_abort, strobes(), packet_send); end
      tick();
      n_cmp++; if (get_source !== 1'b0 || pkt_abort !== 1'b0) begin n_err++; $display("FAIL drop_hold got src=%b abort=%b want 0/0", get_source, pkt_abort); end
      packet_valid_i = 1'b0;
      tick();
      n_cmp++; if (get_source !== 1'b1 || wr_cnt !== 0 || abort_cnt !== 1) begin n_err++; $display("FAIL drop_exit got src=%b wr=%0d abort=%0d want 1/0/1", get_source, wr_cnt, abort_cnt); end
      trusted_source = 1'b1;
      tick();
   endtask

   task automatic test_fifo_full();
      clear_counts();
      trusted_source = 1'b1; err = 1'b0; pkt_size = 3'd4; packet_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      fifo_full = 1'b1;
      #1;
      n_cmp++; if (full_state !== 1'b1 || packet_send !== 1'b0) begin n_err++; $display("FAIL full_c0 got full=%b send=%b want 1/0", full_state, packet_send); end
      tick();
      n_cmp++; if (full_state !== 1'b1 || packet_send !== 1'b0 || load_data !== 1'b1 || write_enb !== 1'b0) begin n_err++; $display("FAIL full_c1 got full=%b send=%b ld=%b we=%b want 1/0/1/0", full_state, packet_send, load_data, write_enb); end
      tick();
      fifo_full = 1'b0;
      #1;
      n_cmp++; if (full_state !== 1'b0 || packet_send !== 1'b1) begin n_err++; $display("FAIL full_release got full=%b send=%b want 0/1", full_state, packet_send); end
      tick(); tick();
      n_cmp++; if (load_data !== 1'b1) begin n_err++; $display("FAIL full_cnt_held got load_data=%b want 1", load_data); end
      tick();
      n_cmp++; if (get_crc !== 1'b1) begin n_err++; $display("FAIL full_to_crc got get_crc=%b want 1", get_crc); end
      tick();
      packet_valid_i = 1'b0;
      tick(); tick();
      n_cmp++; if (wr_cnt !== 8 || done_cnt !== 1) begin n_err++; $display("FAIL full_writes got wr=%0d done=%0d want 8/1", wr_cnt, done_cnt); end
   endtask

   task automatic test_size_zero();
      clear_counts();
      trusted_source = 1'b1; err = 1'b0; pkt_size = 3'd0; packet_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++; if (get_crc !== 1'b1 || load_data !== 1'b0) begin n_err++; $display("FAIL size0_skip got crc=%b ld=%b want 1/0", get_crc, load_data); end
      tick();
      packet_valid_i = 1'b0;
      tick(); tick();
      n_cmp++; if (wr_cnt !== 4 || done_cnt !== 1) begin n_err++; $display("FAIL size0_writes got wr=%0d done=%0d want 4/1", wr_cnt, done_cnt); end
   endtask

   task automatic test_reset_mid();
      clear_counts();
      trusted_source = 1'b1; pkt_size = 3'd5; packet_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      n_cmp++; if (load_data !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got load_data=%b want 1", load_data); end
      reset = 1'b0;
      tick();
      n_cmp++; if (get_source !== 1'b1 || write_enb !== 1'b0 || load_data !== 1'b0) begin n_err++; $display("FAIL rstmid_state got src=%b we=%b ld=%b want 1/0/0", get_source, write_enb, load_data); end
      reset = 1'b1; packet_valid_i = 1'b0;
      tick(); tick();
      n_cmp++; if (abort_cnt !== 0 || done_cnt !== 0 || get_source !== 1'b1) begin n_err++; $display("FAIL rstmid_quiet got abort=%0d done=%0d src=%b want 0/0/1", abort_cnt, done_cnt, get_source); end
   endtask

`ifdef ROUTER_TIMEOUT_EN
   task automatic test_timeout();
      clear_counts();
      trusted_source = 1'b1; pkt_size = 3'd5; packet_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      packet_valid_i = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      n_cmp++; if (abort_cnt !== 0 || load_data !== 1'b1) begin n_err++; $display("FAIL timeout_early got abort=%0d ld=%b want 0/1", abort_cnt, load_data); end
      tick();
      n_cmp++; if (pkt_abort !== 1'b1 || get_source !== 1'b1) begin n_err++; $display("FAIL timeout_fire got abort=%b src=%b want 1/1", pkt_abort, get_source); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_good_packet(3'd3, 1'b0, 7, "good");
      test_good_packet(3'd3, 1'b1, 7, "crcbad");
      test_drop();
      test_fifo_full();
      test_size_zero();
      test_reset_mid();
`ifdef ROUTER_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
